imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Writer-side counterpart of the instruction memory. Receives a program as a byte stream, assembles 32-bit little-endian words, and drives word-aligned write cycles into the instruction RAM.
- Holds the ARM single-cycle core off (cpu_hold) while loading.
- Sits between a byte source (UART receiver or bench) and the RAM write port, alongside the existing combinational read port.

Parameters:
- DEPTH, 64, instruction RAM size in 32-bit words; maximum program length.
- LEN_W, 16, width of the length header field in bits; header is LEN_W/8 bytes, little-endian.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (asserted at 0).
- start  in  1  single-cycle pulse; begins a load session.
- in_valid  in  1  byte source has in_data valid.
- in_data  in  8  stream byte.
- in_ready  out  1  loader accepts a byte this cycle.
- mem_we  out  1  RAM write enable, one cycle per word.
- mem_addr  out  32  byte address, always word aligned (bits [1:0]=0); RAM indexes with mem_addr[31:2].
- mem_wdata  out  32  assembled word.
- busy  out  1  session in progress.
- done  out  1  load completed successfully; sticky until next start or reset.
- error  out  1  length overflow or checksum failure; sticky until next start or reset.
- cpu_hold  out  1  core held off; equals busy.

Behaviour:
- Reset (reset=0, async): state IDLE; all outputs 0; word counter, byte index, length and address registers cleared.
- A byte is transferred when in_valid && in_ready on a rising edge.
- in_ready=1 only in LEN and DATA (and CSUM when enabled); 0 in IDLE, WRITE, DONE and ERR.
- States and transitions:
  - IDLE: start -> LEN.
  - LEN: collect LEN_W/8 bytes, LSB first, into len. On the last byte:
    - len==0 -> DONE.
    - len>DEPTH -> ERR.
    - otherwise -> DATA.
  - DATA: collect 4 bytes, byte i goes to word bits [8i+7:8i]. On the 4th byte -> WRITE.
  - WRITE: exactly one cycle.
    - mem_we=1, mem_addr=4*wcnt, mem_wdata=assembled word.
    - Next edge: wcnt+=1.
    - If wcnt+1==len -> DONE (or CSUM when the feature is enabled); else -> DATA.
  - DONE: done=1, busy=0.
  - ERR: error=1, busy=0.
  - start in DONE or ERR clears done/error and wcnt, and enters LEN.
- start while busy is ignored.
- Address arithmetic:
  - mem_addr = {wcnt, 2'b00}, zero-extended to 32 bits.
  - wcnt width is clog2(DEPTH+1).
  - Never wraps: len<=DEPTH is guaranteed before DATA.
- Latency: a write occurs 1 cycle after the 4th data byte of each word. Minimum session length = LEN_W/8 + 5*len cycles, plus 1 cycle for the start transition.
- in_valid gaps: the state holds and partial bytes are retained indefinitely; there is no timeout.
- Reset mid-session: immediate abort to IDLE; mem_we drops asynchronously; RAM contents already written are left as is.
- mem_wdata and mem_addr are don't-care when mem_we=0 but must hold registered values, with no X after reset.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- With the macro defined:
  - After the last data word, the loader enters CSUM and collects 4 more bytes, little-endian.
  - Equal to the mod-2^32 sum of all data words -> DONE; mismatch -> ERR.
  - For len==0, the loader still reads a checksum; it must equal 0.
  - All words are already written before the check.
- Without the macro: no trailer and no CSUM state; DATA/WRITE proceed directly to DONE.

Decomposition:
- Package imem_loader_pkg holds:
  - state enum (IDLE, LEN, DATA, WRITE, CSUM, DONE, ERR);
  - constants WORD_BYTES=4 and IMEM_DEPTH_DEFAULT=64.
- Natural sub-module: byte_packer (shift register plus 2-bit byte index). Emits word_valid after 4 accepted bytes; reused for LEN and CSUM assembly.

Test Plan:
- Reset mid-DATA (after 2 bytes of word 1) -> mem_we=0 immediately, busy=0. After a fresh start, the program loads correctly from address 0.
- start; bytes 02 00 | 01 00 A0 E3 | 02 10 A0 E3 -> writes 0xE3A00001 @0x0 and 0xE3A01002 @0x4, one mem_we pulse each, then done=1, cpu_hold=0.
- Length 0x0041 (65 > DEPTH) -> error=1, no mem_we pulse, in_ready=0 afterward.
- Length 0 -> done=1 directly with no writes; with checksum 00 00 00 00 enabled, done=1.
- Load 64 words with in_valid toggling randomly -> last write at mem_addr=0xFC, done=1; a stray in_valid afterward is not accepted.
- Checksum enabled, 2 words as above with trailer 03 10 41 C7 (correct sum) -> done=1; with trailer 00 00 00 00 -> error=1, both words still written.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN,
        ST_DATA,
        ST_WRITE,
        ST_CSUM,
        ST_DONE,
        ST_ERR
    } state_t;

    localparam int WORD_BYTES         = 4;
    localparam int IMEM_DEPTH_DEFAULT = 64;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Little-endian byte-to-word assembler; byte i lands in bits [8i+7:8i].
// word_next shows the word including the byte being accepted this cycle.
module imem_loader_byte_packer
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        take,
    input  logic [7:0]  din,
    input  logic [1:0]  last_idx,
    output logic [31:0] word,
    output logic [31:0] word_next,
    output logic        word_valid
);

    logic [1:0] idx;

    always_comb begin
        word_next = word;
        word_next[8*idx +: 8] = din;
        word_valid = take && (idx == last_idx);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            word <= '0;
            idx  <= '0;
        end else if (clear) begin
            word <= '0;
            idx  <= '0;
        end else if (take) begin
            word <= word_next;
            idx  <= word_valid ? 2'd0 : idx + 2'd1;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Byte-stream program loader driving the instruction RAM write port.
// Define IMEM_LOADER_CHECKSUM_EN to require a 32-bit sum trailer after the data.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int DEPTH = IMEM_DEPTH_DEFAULT,
    parameter int LEN_W = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic        cpu_hold
);

    localparam int          WCNT_W    = $clog2(DEPTH + 1);
    localparam logic [1:0]  LEN_LAST  = 2'(LEN_W / 8 - 1);
    localparam logic [1:0]  WORD_LAST = 2'(WORD_BYTES - 1);
    localparam logic [31:0] DEPTH_W   = 32'(DEPTH);
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam state_t      ST_TAIL   = ST_CSUM;
`else
    localparam state_t      ST_TAIL   = ST_DONE;
`endif

    state_t              state, state_n;
    logic [LEN_W-1:0]    len;
    logic [WCNT_W-1:0]   wcnt;
    logic                take;
    logic                pk_clear;
    logic                pk_valid;
    logic [1:0]          pk_last;
    logic [31:0]         pk_word;
    logic [31:0]         pk_word_next;
    logic                last_word;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [31:0]         csum;
`endif

    assign take      = in_valid && in_ready;
    assign last_word = (32'(wcnt) + 32'd1) == 32'(len);

    imem_loader_byte_packer u_packer (
        .clk        (clk),
        .reset      (reset),
        .clear      (pk_clear),
        .take       (take),
        .din        (in_data),
        .last_idx   (pk_last),
        .word       (pk_word),
        .word_next  (pk_word_next),
        .word_valid (pk_valid)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n  = state;
        in_ready = 1'b0;
        pk_clear = 1'b0;
        pk_last  = WORD_LAST;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_n  = ST_LEN;
                    pk_clear = 1'b1;
                end
            end
            ST_LEN: begin
                in_ready = 1'b1;
                pk_last  = LEN_LAST;
                // Unused upper header bytes stay zero, so the full word is the length.
                if (pk_valid) begin
                    if (pk_word_next == 32'd0)       state_n = ST_TAIL;
                    else if (pk_word_next > DEPTH_W) state_n = ST_ERR;
                    else                             state_n = ST_DATA;
                end
            end
            ST_DATA: begin
                in_ready = 1'b1;
                if (pk_valid) state_n = ST_WRITE;
            end
            ST_WRITE: begin
                state_n = last_word ? ST_TAIL : ST_DATA;
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            ST_CSUM: begin
                in_ready = 1'b1;
                if (pk_valid) state_n = (pk_word_next == csum) ? ST_DONE : ST_ERR;
            end
`endif
            ST_DONE, ST_ERR: begin
                if (start) begin
                    state_n  = ST_LEN;
                    pk_clear = 1'b1;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            len  <= '0;
            wcnt <= '0;
        end else begin
            if (pk_clear) wcnt <= '0;
            if (state == ST_LEN && pk_valid) len <= pk_word_next[LEN_W-1:0];
            if (state == ST_WRITE) wcnt <= wcnt + 1'b1;
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                 csum <= '0;
        else if (pk_clear)          csum <= '0;
        else if (state == ST_WRITE) csum <= csum + pk_word;
    end
`endif

    assign mem_we    = (state == ST_WRITE);
    assign mem_addr  = {{(30 - WCNT_W){1'b0}}, wcnt, 2'b00};
    assign mem_wdata = pk_word;
    assign busy      = (state == ST_LEN) || (state == ST_DATA) ||
                       (state == ST_WRITE) || (state == ST_CSUM);
    assign done      = (state == ST_DONE);
    assign error     = (state == ST_ERR);
    assign cpu_hold  = busy;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader; checksum steps follow IMEM_LOADER_CHECKSUM_EN.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        busy;
    logic        done;
    logic        error;
    logic        cpu_hold;

    int checks = 0;
    int errors = 0;

    logic [31:0] wr_addr [0:127];
    logic [31:0] wr_data [0:127];
    int          wr_cnt = 0;

    imem_loader #(.DEPTH(64), .LEN_W(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .cpu_hold  (cpu_hold)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mem_we) begin
            if (wr_cnt < 128) begin
                wr_addr[wr_cnt] = mem_addr;
                wr_data[wr_cnt] = mem_wdata;
            end
            wr_cnt = wr_cnt + 1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        in_data  = b;
        in_valid = 1'b1;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("in_ready_timeout", {31'd0, in_ready}, 32'd1);
        else @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8]);
    endtask

    task automatic wait_end();
        int n;
        n = 0;
        while (!(done || error) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!(done || error)) chk("end_timeout", {31'd0, done}, 32'd1);
    endtask

    function automatic logic [31:0] pat(input int i);
        logic [7:0] b;
        b = 8'(i);
        return {b, ~b, 8'(b * 8'd3), 8'(b + 8'h11)};
    endfunction

    initial begin
        logic [31:0] sum;

        // Reset state
        #12;
        chk("rst_busy",     {31'd0, busy},     32'd0);
        chk("rst_done",     {31'd0, done},     32'd0);
        chk("rst_error",    {31'd0, error},    32'd0);
        chk("rst_mem_we",   {31'd0, mem_we},   32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_cpu_hold", {31'd0, cpu_hold}, 32'd0);
        chk("rst_addr",     mem_addr,          32'd0);
        chk("rst_wdata",    mem_wdata,         32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // Reset in the middle of word 1
        pulse_start();
        chk("s1_busy", {31'd0, busy}, 32'd1);
        send_byte(8'h02); send_byte(8'h00);
        send_word(32'hE3A00001);
        chk("s1_we_latency", {31'd0, mem_we}, 32'd1);
        chk("s1_addr0",      mem_addr,        32'h0);
        chk("s1_data0",      mem_wdata,       32'hE3A00001);
        send_byte(8'h02); send_byte(8'h10);
        #2 reset = 1'b0;
        #1;
        chk("midrst_mem_we",   {31'd0, mem_we},   32'd0);
        chk("midrst_busy",     {31'd0, busy},     32'd0);
        chk("midrst_in_ready", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_writes", wr_cnt, 32'd1);

        // Two-word program from address 0
        wr_cnt = 0;
        pulse_start();
        chk("s2_cpu_hold", {31'd0, cpu_hold}, 32'd1);
        send_byte(8'h02); send_byte(8'h00);
        send_word(32'hE3A00001);
        send_word(32'hE3A01002);
`ifdef IMEM_LOADER_CHECKSUM_EN
        chk("s2_wait_csum", {31'd0, done}, 32'd0);
        send_word(32'hC7411003);
`endif
        wait_end();
        chk("s2_done",     {31'd0, done},     32'd1);
        chk("s2_error",    {31'd0, error},    32'd0);
        chk("s2_cpu_hold_end", {31'd0, cpu_hold}, 32'd0);
        chk("s2_writes",   wr_cnt,            32'd2);
        chk("s2_addr0",    wr_addr[0],        32'h0);
        chk("s2_data0",    wr_data[0],        32'hE3A00001);
        chk("s2_addr1",    wr_addr[1],        32'h4);
        chk("s2_data1",    wr_data[1],        32'hE3A01002);

        // Over-length header
        wr_cnt = 0;
        pulse_start();
        chk("s3_done_cleared", {31'd0, done}, 32'd0);
        send_byte(8'h41); send_byte(8'h00);
        @(negedge clk);
        chk("s3_error",    {31'd0, error},    32'd1);
        chk("s3_done",     {31'd0, done},     32'd0);
        chk("s3_in_ready", {31'd0, in_ready}, 32'd0);
        chk("s3_writes",   wr_cnt,            32'd0);

        // Zero-length program
        pulse_start();
        chk("s4_error_cleared", {31'd0, error}, 32'd0);
        send_byte(8'h00); send_byte(8'h00);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_word(32'h0);
`endif
        wait_end();
        chk("s4_done",   {31'd0, done},  32'd1);
        chk("s4_error",  {31'd0, error}, 32'd0);
        chk("s4_writes", wr_cnt,         32'd0);

        // Full 64-word program with random gaps and a start pulse while busy
        wr_cnt = 0;
        sum = 32'd0;
        pulse_start();
        send_byte(8'h40); send_byte(8'h00);
        for (int i = 0; i < 64; i++) begin
            for (int k = 0; k < 4; k++) begin
                send_byte(pat(i)[8*k +: 8]);
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
            sum = sum + pat(i);
            if (i == 10) pulse_start();
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_word(sum);
`endif
        wait_end();
        chk("s5_done",      {31'd0, done}, 32'd1);
        chk("s5_writes",    wr_cnt,        32'd64);
        chk("s5_last_addr", wr_addr[63],   32'hFC);
        for (int i = 0; i < 64; i++) begin
            chk($sformatf("s5_addr%0d", i), wr_addr[i], 32'(4 * i));
            chk($sformatf("s5_data%0d", i), wr_data[i], pat(i));
        end
        in_valid = 1'b1;
        in_data  = 8'hAA;
        #1;
        chk("s5_stray_ready", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
        chk("s5_stray_done",   {31'd0, done}, 32'd1);
        chk("s5_stray_writes", wr_cnt,        32'd64);

`ifdef IMEM_LOADER_CHECKSUM_EN
        // Wrong checksum still writes both words
        wr_cnt = 0;
        pulse_start();
        send_byte(8'h02); send_byte(8'h00);
        send_word(32'hE3A00001);
        send_word(32'hE3A01002);
        send_word(32'h0);
        wait_end();
        chk("s6_error",  {31'd0, error}, 32'd1);
        chk("s6_done",   {31'd0, done},  32'd0);
        chk("s6_writes", wr_cnt,         32'd2);
        chk("s6_data1",  wr_data[1],     32'hE3A01002);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
